// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scan/debounce path: FSM states,
// key legend table and 16-bit one-hot helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } kp_state_e;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Indexed by col*4 + row; each group of four is one column, rows 0..3.
  localparam logic [3:0] LEGEND [0:15] = '{
    4'h1, 4'h4, 4'h7, KEY_STAR,
    4'h2, 4'h5, 4'h8, 4'h0,
    4'h3, 4'h6, 4'h9, KEY_HASH,
    4'hA, 4'hB, 4'hC, 4'hD
  };

  function automatic logic onehot16(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

  function automatic logic [3:0] enc16(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      idx = v[i] ? 4'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_column_scanner.sv
// Column drive and row sampling: synchronises the rows, walks the active-low
// column one-hot every SCAN_DIV cycles and assembles a 16-bit frame snapshot.
module keypad_column_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rows,
  output logic [3:0]  columns,
  output logic        frame_done,
  output logic [15:0] snapshot
);

  localparam int DW_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(SCAN_DIV - 1);

  logic [3:0]      rows_meta_q, rows_meta_d;
  logic [3:0]      rows_sync_q, rows_sync_d;
  logic [1:0]      col_q, col_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [3:0]      columns_q, columns_d;
  logic [15:0]     snapshot_q, snapshot_d;
  logic            frame_done_q, frame_done_d;

  // Next-state: synchroniser shift, dwell/column advance, snapshot capture.
  always_comb begin
    rows_meta_d  = rows;
    rows_sync_d  = rows_meta_q;
    dwell_d      = dwell_q + DW_W'(1);
    col_d        = col_q;
    columns_d    = columns_q;
    snapshot_d   = snapshot_q;
    frame_done_d = 1'b0;
    if (dwell_q == DW_LAST) begin
      dwell_d    = {DW_W{1'b0}};
      col_d      = col_q + 2'd1;
      columns_d  = ~(4'b0001 << col_d);
      // Rows are active-low on the pins; snapshot bits are 1 = pressed.
      snapshot_d[{col_q, 2'b00} +: 4] = ~rows_sync_q;
      frame_done_d = (col_q == 2'd3);
    end else begin
      col_d = col_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_meta_q  <= 4'hF;
      rows_sync_q  <= 4'hF;
      col_q        <= 2'd0;
      dwell_q      <= {DW_W{1'b0}};
      columns_q    <= 4'b1110;
      snapshot_q   <= 16'd0;
      frame_done_q <= 1'b0;
    end else begin
      rows_meta_q  <= rows_meta_d;
      rows_sync_q  <= rows_sync_d;
      col_q        <= col_d;
      dwell_q      <= dwell_d;
      columns_q    <= columns_d;
      snapshot_q   <= snapshot_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign columns    = columns_q;
  assign frame_done = frame_done_q;
  assign snapshot   = snapshot_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad scanner with frame-based debounce producing clean key events.
// Optional auto-repeat while held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV            = 1000,
  parameter int DEBOUNCE_FRAMES     = 125,
  parameter int REPEAT_DELAY_FRAMES = 6250,
  parameter int REPEAT_RATE_FRAMES  = 1250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       key_release,
  output logic       multi_key
);

  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_FRAMES);

  if (SCAN_DIV < 4 || DEBOUNCE_FRAMES < 1 ||
      REPEAT_DELAY_FRAMES < 1 || REPEAT_RATE_FRAMES < 1) begin : g_bad_params
    $error("keypad_scan_debounce: illegal parameter value");
  end

  logic        frame_done;
  logic [15:0] snapshot;

  keypad_column_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
    .clk        (clk),
    .rst_n      (rst_n),
    .rows       (rows),
    .columns    (columns),
    .frame_done (frame_done),
    .snapshot   (snapshot)
  );

  kp_state_e        state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_down_q, key_down_d;
  logic             key_release_q, key_release_d;
  logic             multi_key_q, multi_key_d;
  logic             frame_zero, frame_single;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_TOP = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                           REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
  localparam int REP_W = $clog2(REP_TOP + 1);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d, rep_inc, rep_thr;
  logic             rep_first_q, rep_first_d;
`endif

  // Debounce FSM: all transitions are taken on frame_done only.
  always_comb begin
    frame_zero    = (snapshot == 16'd0);
    frame_single  = onehot16(snapshot);
    cnt_inc       = (cnt_q == DB_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    state_d       = state_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_down_d    = key_down_q;
    key_release_d = 1'b0;
    multi_key_d   = multi_key_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_inc     = (rep_cnt_q == REP_W'(REP_TOP)) ? rep_cnt_q : rep_cnt_q + REP_W'(1);
    rep_thr     = rep_first_q ? REP_W'(REPEAT_DELAY_FRAMES) : REP_W'(REPEAT_RATE_FRAMES);
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
`endif
    if (frame_done) begin
      multi_key_d = !frame_zero && !frame_single;
      case (state_q)
        IDLE: begin
          if (frame_single) begin
            cand_d  = enc16(snapshot);
            cnt_d   = CNT_W'(1);
            state_d = DB_PRESS;
          end else begin
            state_d = IDLE;
          end
        end
        DB_PRESS: begin
          if (snapshot == (16'd1 << cand_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_MAX) begin
              state_d     = PRESSED;
              key_code_d  = LEGEND[cand_q];
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt_d   = {REP_W{1'b0}};
              rep_first_d = 1'b1;
`endif
            end else begin
              state_d = DB_PRESS;
            end
          end else begin
            state_d = IDLE;
          end
        end
        PRESSED: begin
          if (frame_zero) begin
            cnt_d   = CNT_W'(1);
            state_d = DB_RELEASE;
          end else begin
            // Held key keeps ownership even if other keys join or it is masked.
            state_d = PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rep_inc == rep_thr) begin
              key_valid_d = 1'b1;
              rep_cnt_d   = {REP_W{1'b0}};
              rep_first_d = 1'b0;
            end else begin
              rep_cnt_d = rep_inc;
            end
`endif
          end
        end
        DB_RELEASE: begin
          if (frame_zero) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_MAX) begin
              state_d       = IDLE;
              key_down_d    = 1'b0;
              key_release_d = 1'b1;
            end else begin
              state_d = DB_RELEASE;
            end
          end else if (snapshot[cand_q]) begin
            state_d = PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_d   = {REP_W{1'b0}};
            rep_first_d = 1'b1;
`endif
          end else begin
            state_d = DB_RELEASE;
          end
        end
        default: begin
          state_d    = IDLE;
          key_down_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cand_q        <= 4'd0;
      cnt_q         <= {CNT_W{1'b0}};
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_down_q    <= 1'b0;
      key_release_q <= 1'b0;
      multi_key_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q     <= {REP_W{1'b0}};
      rep_first_q   <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_down_q    <= key_down_d;
      key_release_q <= key_release_d;
      multi_key_q   <= multi_key_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q     <= rep_cnt_d;
      rep_first_q   <= rep_first_d;
`endif
    end
  end

  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_down    = key_down_q;
  assign key_release = key_release_q;
  assign multi_key   = multi_key_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Scoreboard bench for keypad_scan_debounce with a behavioural 4x4 keypad.
module tb_keypad_scan_debounce;

  localparam int SCAN_DIV = 4;
  localparam int DBF      = 3;
  localparam int FRAME    = 4 * SCAN_DIV;
  localparam int LAT      = DBF * FRAME + 1;

  logic       clk;
  logic       rst_n;
  logic [3:0] rows;
  logic [3:0] columns;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       key_release;
  logic       multi_key;

  logic [15:0] keys;
  int          cyc;
  int          checks;
  int          errors;

  typedef struct {
    bit         rel;
    logic [3:0] code;
    int         at;
  } ev_t;
  ev_t sb[$];

  keypad_scan_debounce #(
    .SCAN_DIV            (SCAN_DIV),
    .DEBOUNCE_FRAMES     (DBF),
    .REPEAT_DELAY_FRAMES (5),
    .REPEAT_RATE_FRAMES  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rows        (rows),
    .columns     (columns),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_down    (key_down),
    .key_release (key_release),
    .multi_key   (multi_key)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad model: a pressed key at (row r, col c) pulls row r low while column c is low.
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!columns[c] && keys[c*4+r]) rows[r] = 1'b0;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Scoreboard monitor: every event pulse is matched against the next expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid && key_release) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL exclusive_pulses valid=%b release=%b at cyc=%0d", key_valid, key_release, cyc);
      end
      if (key_valid || key_release) begin
        checks = checks + 1;
        if (sb.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_event rel=%b code=%h cyc=%0d expected none", key_release, key_code, cyc);
        end else begin
          ev_t e;
          e = sb.pop_front();
          if ({key_release, key_code} !== {e.rel, e.code} || cyc !== e.at) begin
            errors = errors + 1;
            $display("FAIL sb_event got rel=%b code=%h cyc=%0d expected rel=%b code=%h cyc=%0d",
                     key_release, key_code, cyc, e.rel, e.code, e.at);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      while (cyc % FRAME != 0) @(negedge clk);
    end
  endtask

  task automatic expect_ev(input bit rel, input logic [3:0] code, input int at);
    ev_t e;
    e.rel  = rel;
    e.code = code;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic check_drained(input string name);
    checks = checks + 1;
    if (sb.size() !== 0) begin
      errors = errors + 1;
      $display("FAIL %s pending_events got %0d expected 0 (next at cyc %0d)", name, sb.size(), sb[0].at);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    logic [3:0] one;
    logic [3:0] exp_col;
    one   = 4'b0001;
    rst_n = 1'b0;
    keys  = 16'd0;
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (columns !== 4'b1110) begin
      errors = errors + 1;
      $display("FAIL reset_columns got %b expected 1110", columns);
    end
    checks = checks + 1;
    if ({key_code, key_valid, key_down, key_release, multi_key} !== 8'h00) begin
      errors = errors + 1;
      $display("FAIL reset_outputs got code=%h v=%b d=%b r=%b m=%b expected all 0",
               key_code, key_valid, key_down, key_release, multi_key);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      exp_col = ~(one << ((cyc / SCAN_DIV) % 4));
      checks = checks + 1;
      if (columns !== exp_col || {key_valid, key_down, key_release, multi_key} !== 4'b0000) begin
        errors = errors + 1;
        $display("FAIL idle_scan cyc=%0d got col=%b v=%b d=%b r=%b m=%b expected col=%b events 0",
                 cyc, columns, key_valid, key_down, key_release, multi_key, exp_col);
      end
    end
  endtask

  task automatic test_single_key();
    wait_frames(1);
    keys = 16'd1 << 5;
    expect_ev(1'b0, 4'h5, cyc + LAT);
    wait_frames(10);
    checks = checks + 1;
    if (key_down !== 1'b1 || key_code !== 4'h5) begin
      errors = errors + 1;
      $display("FAIL key5_held got down=%b code=%h expected down=1 code=5", key_down, key_code);
    end
    keys = 16'd0;
    expect_ev(1'b1, 4'h5, cyc + LAT);
    wait_frames(4);
    @(negedge clk);
    checks = checks + 1;
    if (key_down !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL key5_released got down=%b expected 0", key_down);
    end
    check_drained("single_key");
  endtask

  task automatic test_bounce();
    wait_frames(1);
    keys = 16'd1 << 11;
    wait_frames(2);
    keys = 16'd0;
    wait_frames(1);
    keys = 16'd1 << 11;
    expect_ev(1'b0, 4'hF, cyc + LAT);
    wait_frames(4);
    keys = 16'd0;
    expect_ev(1'b1, 4'hF, cyc + LAT);
    wait_frames(4);
    check_drained("bounce");
  endtask

  task automatic test_multi();
    wait_frames(1);
    keys = (16'd1 << 0) | (16'd1 << 15);
    wait_frames(2);
    @(negedge clk);
    checks = checks + 1;
    if (multi_key !== 1'b1 || key_down !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL multi_held got multi=%b down=%b expected multi=1 down=0", multi_key, key_down);
    end
    wait_frames(1);
    keys = 16'd1 << 0;
    expect_ev(1'b0, 4'h1, cyc + LAT);
    wait_frames(2);
    @(negedge clk);
    checks = checks + 1;
    if (multi_key !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL multi_cleared got %b expected 0", multi_key);
    end
    wait_frames(3);
    keys = 16'd0;
    expect_ev(1'b1, 4'h1, cyc + LAT);
    wait_frames(4);
    check_drained("multi");
  endtask

  task automatic test_second_key();
    wait_frames(1);
    keys = 16'd1 << 6;
    expect_ev(1'b0, 4'h8, cyc + LAT);
    wait_frames(4);
    keys = (16'd1 << 6) | (16'd1 << 8);
    wait_frames(3);
    keys = 16'd1 << 8;
    wait_frames(4);
    @(negedge clk);
    checks = checks + 1;
    if (key_down !== 1'b1 || key_code !== 4'h8) begin
      errors = errors + 1;
      $display("FAIL second_key_hold got down=%b code=%h expected down=1 code=8", key_down, key_code);
    end
    wait_frames(1);
    keys = 16'd0;
    expect_ev(1'b1, 4'h8, cyc + LAT);
    wait_frames(4);
    check_drained("second_key");
  endtask

  task automatic test_reset_mid_release();
    wait_frames(1);
    keys = 16'd1 << 4;
    expect_ev(1'b0, 4'h2, cyc + LAT);
    wait_frames(5);
    keys = 16'd0;
    wait_frames(1);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks = checks + 1;
    if ({columns, key_code, key_valid, key_down, key_release, multi_key} !== 12'hE00) begin
      errors = errors + 1;
      $display("FAIL async_reset got col=%b code=%h v=%b d=%b r=%b m=%b expected col=1110 rest 0",
               columns, key_code, key_valid, key_down, key_release, multi_key);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_frames(5);
    checks = checks + 1;
    if (key_down !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL post_reset_down got %b expected 0", key_down);
    end
    check_drained("reset_mid_release");
  endtask

  task automatic test_autorepeat();
    int p0;
    wait_frames(1);
    p0   = cyc;
    keys = 16'd1 << 7;
    expect_ev(1'b0, 4'h0, p0 + 3 * FRAME + 1);
`ifdef KEYPAD_AUTOREPEAT_EN
    for (int k = 8; k <= 14; k += 2) begin
      expect_ev(1'b0, 4'h0, p0 + k * FRAME + 1);
    end
`endif
    wait_frames(15);
    keys = 16'd0;
    expect_ev(1'b1, 4'h0, cyc + LAT);
    wait_frames(4);
    check_drained("autorepeat");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    keys   = 16'd0;
    rst_n  = 1'b0;
    test_reset();
    test_single_key();
    test_bounce();
    test_multi();
    test_second_key();
    test_reset_mid_release();
    test_autorepeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
